// File: rtl/l4_hdr_sequencer.sv
// Passive tap on a 32-bit Ethernet stream: extracts the IPv4 protocol and the L4 ports,
// then issues one registered result strobe per packet, the cycle after eop.
module l4_hdr_sequencer #(
    parameter int MAX_VLAN = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] snk_data_i,
    input  logic        snk_valid_i,
    input  logic        snk_sop_i,
    input  logic        snk_eop_i,
    output logic [7:0]  ip_prot_o,
    output logic        ip_prot_en_o,
    output logic [15:0] port_src_o,
    output logic        port_src_en_o,
    output logic [15:0] port_dst_o,
    output logic        port_dst_en_o,
    output logic        res_valid_o,
    output logic        trunc_o
);

    typedef enum logic [2:0] {IDLE, ETH, IP, L4, WAIT_EOP} state_t;

    state_t      state_q, state_d, cur_st;
    logic [5:0]  wcnt_q, wcnt_d, idx;
    logic [1:0]  vlan_q, vlan_d, k;
    logic [3:0]  ihl_q, ihl_d;
    logic [7:0]  prot_q, prot_d;
    logic        prot_en_q, prot_en_d;
    logic [15:0] src_q, src_d, dst_q, dst_d;
    logic        src_en_q, src_en_d, dst_en_q, dst_en_d;
    logic        res_d, trunc_d;
    logic [15:0] etype;
    logic [5:0]  eth_w, ip_w, src_w, dst_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A sop beat restarts parsing from any state, which also drops a packet that lost its eop.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        vlan_d    = vlan_q;
        ihl_d     = ihl_q;
        prot_d    = prot_q;
        prot_en_d = prot_en_q;
        src_d     = src_q;
        src_en_d  = src_en_q;
        dst_d     = dst_q;
        dst_en_d  = dst_en_q;
        res_d     = 1'b0;
        trunc_d   = 1'b0;
        cur_st    = snk_sop_i ? ETH : state_q;
        k         = snk_sop_i ? 2'd0 : vlan_q;
        idx       = snk_sop_i ? 6'd0 : wcnt_q;
        etype     = snk_data_i[31:16];
        eth_w     = 6'd3 + {4'd0, k};
        ip_w      = 6'd5 + {4'd0, k};
        src_w     = 6'd3 + {4'd0, k} + {2'd0, ihl_q};
        dst_w     = src_w + 6'd1;
        if (snk_valid_i) begin
            if (snk_sop_i) begin
                state_d   = ETH;
                vlan_d    = 2'd0;
                ihl_d     = 4'd0;
                prot_d    = 8'd0;
                prot_en_d = 1'b0;
                src_d     = 16'd0;
                src_en_d  = 1'b0;
                dst_d     = 16'd0;
                dst_en_d  = 1'b0;
            end
            wcnt_d = (idx == 6'd63) ? 6'd63 : idx + 6'd1;
            case (cur_st)
                ETH: if (idx == eth_w) begin
                    if ((etype == 16'h8100 || etype == 16'h88A8) && int'(k) < MAX_VLAN)
                        vlan_d = k + 2'd1;
                    else if (etype == 16'h0800 && snk_data_i[15:12] == 4'd4 &&
                             snk_data_i[11:8] >= 4'd5) begin
                        ihl_d   = snk_data_i[11:8];
                        state_d = IP;
                    end else
                        state_d = WAIT_EOP;
                end
                IP: if (idx == ip_w) begin
                    prot_d    = snk_data_i[7:0];
                    prot_en_d = 1'b1;
                    // MF flag or non-zero offset: ports are not in this fragment
                    state_d   = (snk_data_i[29] || snk_data_i[28:16] != 13'd0) ? WAIT_EOP : L4;
                end
                L4: if (idx == src_w) begin
                    src_d    = snk_data_i[15:0];
                    src_en_d = 1'b1;
                end else if (idx == dst_w) begin
                    dst_d    = snk_data_i[31:16];
                    dst_en_d = 1'b1;
                    state_d  = WAIT_EOP;
                end
                default: ;
            endcase
            if (snk_eop_i && cur_st != IDLE) begin
                res_d   = 1'b1;
                trunc_d = (state_d == ETH || state_d == IP || state_d == L4);
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q        <= 6'd0;
            vlan_q        <= 2'd0;
            ihl_q         <= 4'd0;
            prot_q        <= 8'd0;
            prot_en_q     <= 1'b0;
            src_q         <= 16'd0;
            src_en_q      <= 1'b0;
            dst_q         <= 16'd0;
            dst_en_q      <= 1'b0;
            res_valid_o   <= 1'b0;
            trunc_o       <= 1'b0;
            ip_prot_o     <= 8'd0;
            ip_prot_en_o  <= 1'b0;
            port_src_o    <= 16'd0;
            port_src_en_o <= 1'b0;
            port_dst_o    <= 16'd0;
            port_dst_en_o <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            vlan_q      <= vlan_d;
            ihl_q       <= ihl_d;
            prot_q      <= prot_d;
            prot_en_q   <= prot_en_d;
            src_q       <= src_d;
            src_en_q    <= src_en_d;
            dst_q       <= dst_d;
            dst_en_q    <= dst_en_d;
            res_valid_o <= res_d;
            // captures from the eop beat itself are taken from the _d side
            if (res_d) begin
                trunc_o       <= trunc_d;
                ip_prot_o     <= prot_d;
                ip_prot_en_o  <= prot_en_d;
                port_src_o    <= src_d;
                port_src_en_o <= src_en_d;
                port_dst_o    <= dst_d;
                port_dst_en_o <= dst_en_d;
            end
        end
    end

endmodule

// File: tb/tb_l4_hdr_sequencer.sv
// Bench for l4_hdr_sequencer: table of packets built byte-wise, expected results queued at eop
// and compared when each strobe appears; a MAX_VLAN=1 instance shares the stimulus.
module tb_l4_hdr_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] snk_data_i = '0;
    logic        snk_valid_i = 1'b0, snk_sop_i = 1'b0, snk_eop_i = 1'b0;

    logic [7:0]  a_prot, b_prot;
    logic [15:0] a_src, a_dst, b_src, b_dst;
    logic        a_prot_en, a_src_en, a_dst_en, a_res, a_trunc;
    logic        b_prot_en, b_src_en, b_dst_en, b_res, b_trunc;

    l4_hdr_sequencer #(.MAX_VLAN(2)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i),
        .snk_sop_i(snk_sop_i), .snk_eop_i(snk_eop_i),
        .ip_prot_o(a_prot), .ip_prot_en_o(a_prot_en), .port_src_o(a_src), .port_src_en_o(a_src_en),
        .port_dst_o(a_dst), .port_dst_en_o(a_dst_en), .res_valid_o(a_res), .trunc_o(a_trunc));

    l4_hdr_sequencer #(.MAX_VLAN(1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i),
        .snk_sop_i(snk_sop_i), .snk_eop_i(snk_eop_i),
        .ip_prot_o(b_prot), .ip_prot_en_o(b_prot_en), .port_src_o(b_src), .port_src_en_o(b_src_en),
        .port_dst_o(b_dst), .port_dst_en_o(b_dst_en), .res_valid_o(b_res), .trunc_o(b_trunc));

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       nm;
        int          ntag;
        logic [15:0] tp0, tp1, tp2, etype;
        logic [3:0]  ihl;
        logic [7:0]  prot;
        logic [15:0] frag, src, dst;
        int          len;
        logic [7:0]  e_prot;
        logic        e_prot_en;
        logic [15:0] e_src;
        logic        e_src_en;
        logic [15:0] e_dst;
        logic        e_dst_en, e_trunc, b_zero;
    } vec_t;

    typedef struct {
        string       nm;
        int          cyc;
        logic [7:0]  prot;
        logic        prot_en;
        logic [15:0] src;
        logic        src_en;
        logic [15:0] dst;
        logic        dst_en, trunc;
    } exp_t;

    exp_t        qa[$], qb[$];
    vec_t        vecs[12];
    logic [31:0] pkt[64];
    int          cyc = 0;
    int          n_chk = 0, n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endfunction

    task automatic cmp_res(input exp_t e, input string who, input logic [7:0] p, input logic pe,
                           input logic [15:0] s, input logic se, input logic [15:0] d,
                           input logic de, input logic tr);
        check({who, "_", e.nm, "_cycle"}, cyc, e.cyc);
        check({who, "_", e.nm, "_prot"}, {24'd0, p}, {24'd0, e.prot});
        check({who, "_", e.nm, "_prot_en"}, {31'd0, pe}, {31'd0, e.prot_en});
        check({who, "_", e.nm, "_src"}, {16'd0, s}, {16'd0, e.src});
        check({who, "_", e.nm, "_src_en"}, {31'd0, se}, {31'd0, e.src_en});
        check({who, "_", e.nm, "_dst"}, {16'd0, d}, {16'd0, e.dst});
        check({who, "_", e.nm, "_dst_en"}, {31'd0, de}, {31'd0, e.dst_en});
        check({who, "_", e.nm, "_trunc"}, {31'd0, tr}, {31'd0, e.trunc});
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (a_res) begin
            if (qa.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL a_unexpected_strobe: strobe at cycle %0d, required none", cyc);
            end else begin
                e = qa.pop_front();
                cmp_res(e, "a", a_prot, a_prot_en, a_src, a_src_en, a_dst, a_dst_en, a_trunc);
            end
        end
        if (b_res) begin
            if (qb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL b_unexpected_strobe: strobe at cycle %0d, required none", cyc);
            end else begin
                e = qb.pop_front();
                cmp_res(e, "b", b_prot, b_prot_en, b_src, b_src_en, b_dst, b_dst_en, b_trunc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Packet laid out as bytes on the wire, then packed big-endian into 32-bit words.
    task automatic build(input vec_t v);
        logic [7:0]  b[256];
        logic [15:0] tp[3];
        int          p;
        for (int i = 0; i < 256; i++) b[i] = 8'($urandom);
        tp[0] = v.tp0; tp[1] = v.tp1; tp[2] = v.tp2;
        p = 12;
        for (int t = 0; t < v.ntag; t++) begin
            {b[p], b[p+1]} = tp[t];
            p += 4;
        end
        {b[p], b[p+1]} = v.etype;
        b[p+2] = {4'h4, v.ihl};
        {b[p+8], b[p+9]} = v.frag;
        b[p+11] = v.prot;
        p = p + 2 + 4 * int'(v.ihl);
        {b[p], b[p+1]} = v.src;
        {b[p+2], b[p+3]} = v.dst;
        for (int w = 0; w < 64; w++) pkt[w] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e = '{v.nm, cyc, v.e_prot, v.e_prot_en, v.e_src, v.e_src_en, v.e_dst, v.e_dst_en, v.e_trunc};
        qa.push_back(e);
        if (v.b_zero) e = '{v.nm, cyc, 8'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0};
        qb.push_back(e);
    endtask

    // Sends words [first,last) of the built packet; sop on word 0, eop on the last word if asked.
    task automatic send(input vec_t v, input int first, input int last, input bit eop,
                        input bit push, input int gap_pct);
        for (int w = first; w < last; w++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                snk_valid_i = 1'b0;
                snk_data_i  = $urandom;
                snk_sop_i   = 1'($urandom);
                snk_eop_i   = 1'($urandom);
                tick();
            end
            snk_valid_i = 1'b1;
            snk_data_i  = pkt[w];
            snk_sop_i   = (w == 0);
            snk_eop_i   = eop && (w == last - 1);
            tick();
            if (eop && w == last - 1 && push) push_exp(v);
        end
        snk_valid_i = 1'b0;
        snk_sop_i   = 1'b0;
        snk_eop_i   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"tcp", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h06, 16'h4000, 16'h1234, 16'h0017, 16,
                     8'h06, 1'b1, 16'h1234, 1'b1, 16'h0017, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"qinq", 2, 16'h88A8, 16'h8100, 16'h0, 16'h0800, 4'd6, 8'h11, 16'h0000, 16'h0400, 16'h013F, 16,
                     8'h11, 1'b1, 16'h0400, 1'b1, 16'h013F, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"frag", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h11, 16'h00B9, 16'h5555, 16'h6666, 16,
                     8'h11, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"trunc_w4", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h06, 16'h0000, 16'h1234, 16'h0017, 5,
                     8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{"arp", 0, 16'h0, 16'h0, 16'h0, 16'h0806, 4'd5, 8'h06, 16'h0000, 16'h1234, 16'h0017, 16,
                     8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"vlan1", 1, 16'h8100, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h06, 16'h4000, 16'hABCD, 16'h0050, 16,
                     8'h06, 1'b1, 16'hABCD, 1'b1, 16'h0050, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"eop_on_dst", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h11, 16'h0000, 16'h1111, 16'h2222, 10,
                     8'h11, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"eop_on_src", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h11, 16'h0000, 16'h1111, 16'h2222, 9,
                     8'h11, 1'b1, 16'h1111, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{"one_word", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h06, 16'h0000, 16'h1234, 16'h0017, 1,
                     8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{"mf", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd5, 8'h06, 16'h2000, 16'h1234, 16'h0017, 16,
                     8'h06, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"three_tags", 3, 16'h8100, 16'h8100, 16'h8100, 16'h0800, 4'd5, 8'h06, 16'h0000, 16'h1234, 16'h0017, 16,
                     8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"ihl4", 0, 16'h0, 16'h0, 16'h0, 16'h0800, 4'd4, 8'h06, 16'h0000, 16'h1234, 16'h0017, 16,
                     8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0};

        tick(); tick();
        check("reset_res_valid", {31'd0, a_res}, 32'd0);
        check("reset_fields", {a_prot, a_src, 8'd0}, 32'd0);
        check("reset_en_trunc", {28'd0, a_prot_en, a_src_en, a_dst_en, a_trunc}, 32'd0);
        rst_i = 1'b0;
        tick();

        // table sweep, gap-free and back-to-back
        foreach (vecs[i]) begin
            build(vecs[i]);
            send(vecs[i], 0, vecs[i].len, 1'b1, 1'b1, 0);
        end

        // random valid gaps must not change results
        for (int i = 0; i < 2; i++) begin
            build(vecs[i]);
            send(vecs[i], 0, vecs[i].len, 1'b1, 1'b1, 40);
        end
        repeat (3) tick();

        // lost eop: second sop restarts parsing, no strobe for the dropped packet
        build(vecs[0]);
        send(vecs[0], 0, 7, 1'b0, 1'b0, 0);
        build(vecs[2]);
        send(vecs[2], 0, 16, 1'b1, 1'b1, 0);
        repeat (3) tick();

        // reset mid-packet; the remaining words including eop arrive with no sop
        build(vecs[0]);
        send(vecs[0], 0, 8, 1'b0, 1'b0, 0);
        rst_i = 1'b1;
        #2;
        check("midrst_fields", {a_prot, a_src, 8'd0}, 32'd0);
        check("midrst_en_trunc", {27'd0, a_res, a_prot_en, a_src_en, a_dst_en, a_trunc}, 32'd0);
        rst_i = 1'b0;
        tick();
        send(vecs[0], 8, 16, 1'b1, 1'b0, 0);
        repeat (3) tick();
        build(vecs[5]);
        send(vecs[5], 0, 16, 1'b1, 1'b1, 20);

        // back-to-back pair: strobes 16 cycles apart via the cycle checks
        build(vecs[0]);
        send(vecs[0], 0, 16, 1'b1, 1'b1, 0);
        build(vecs[1]);
        send(vecs[1], 0, 16, 1'b1, 1'b1, 0);

        repeat (5) tick();
        check("a_pending_results", qa.size(), 0);
        check("b_pending_results", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
